// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the 8-requester round-robin arbiter.
//   N_REQ  number of requesters (fixed at 8)
//   SEL_W  width of a requester index (3)
//   DW     data width of each requester word and of the output word (32)
//   arb_state_e  arbiter FSM encoding: IDLE=1'b0, GRANT=1'b1
//   sel_onehot() expands a requester index into an N_REQ-bit one-hot mask
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;
   localparam int DW    = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [N_REQ-1:0] mask;
      mask = {{(N_REQ-1){1'b0}}, 1'b1};
      sel_onehot = mask << sel;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational rotating priority encoder for eight requesters. The search
// starts one position above 'base' (the last granted index) and wraps 7 -> 0,
// so 'base' itself is the lowest-priority candidate. That ordering lets the
// same encoder serve both the idle pick and the re-pick after a transfer: the
// requester just served only wins again when nobody else is asking.
// Ports:
//   request  in  8  request vector, bit i = requester i
//   base     in  3  last granted index; search begins at base+1
//   index    out 3  chosen requester (0 when nothing found)
//   found    out 1  at least one request bit was set
// -----------------------------------------------------------------------------
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] request,
   input  logic [SEL_W-1:0] base,
   output logic [SEL_W-1:0] index,
   output logic             found
);

   // Walk from the farthest candidate back to the nearest so the nearest
   // set bit above 'base' is the last one written and therefore wins.
   always_comb begin
      logic [SEL_W-1:0] cand;
      index = {SEL_W{1'b0}};
      found = 1'b0;
      cand  = {SEL_W{1'b0}};
      for (int i = N_REQ; i >= 1; i--) begin
         cand = base + SEL_W'(i);
         if (request[cand]) begin
            index = cand;
            found = 1'b1;
         end else begin
            index = index;
            found = found;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
// Eight-way round-robin arbiter placing one requester at a time on a shared
// DW-bit result bus. A registered 3-bit select names the granted requester;
// the output word is muxed combinationally from that select, so a request
// seen in cycle t is presented downstream in cycle t+1 and no combinational
// path exists from req_valid to out_valid.
//
// Optional feature (macro ARB_LOCK_EN): adds the req_lock port. A transfer
// from a requester whose lock bit is set, and which is still valid, keeps the
// grant on that requester (multi-word bursts such as HI then LO). The default
// build (macro undefined) has no req_lock port and pure round-robin.
//
// Ports:
//   clk        in  1        rising-edge clock
//   rst_n      in  1        asynchronous active-low reset
//   req_valid  in  8        per-requester valid
//   req_data   in  8*DW     requester i data at [i*DW +: DW]
//   req_lock   in  8        grant-hold request (ARB_LOCK_EN only)
//   req_ready  out 8        one-hot transfer acknowledge
//   out_valid  out 1        output word valid (from the FSM register)
//   out_data   out DW       word of the granted requester
//   out_sel    out 3        granted requester index (registered)
//   out_ready  in  1        downstream accept
// -----------------------------------------------------------------------------
module rr_arbiter8
   import arb_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*DW-1:0] req_data,
`ifdef ARB_LOCK_EN
   input  logic [N_REQ-1:0]    req_lock,
`endif
   output logic [N_REQ-1:0]    req_ready,
   output logic                out_valid,
   output logic [DW-1:0]       out_data,
   output logic [SEL_W-1:0]    out_sel,
   input  logic                out_ready
);

   arb_state_e       state_r;
   arb_state_e       state_nx;
   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] sel_nx;
   logic [SEL_W-1:0] last_r;
   logic [SEL_W-1:0] last_nx;

   logic [SEL_W-1:0] pick_base_s;
   logic [SEL_W-1:0] pick_idx_s;
   logic             pick_found_s;
   logic             xfer_s;
   logic             lock_hold_s;

   // In GRANT a transfer moves the pointer to sel_r in the same edge, so the
   // re-pick searches from sel_r; in IDLE it searches from last_r.
   always_comb begin
      if (state_r == GRANT) begin
         pick_base_s = sel_r;
      end else begin
         pick_base_s = last_r;
      end
   end

   rr_pick8 u_pick (
      .request (req_valid),
      .base    (pick_base_s),
      .index   (pick_idx_s),
      .found   (pick_found_s)
   );

   assign xfer_s = out_valid & out_ready;

`ifdef ARB_LOCK_EN
   // A locked requester that is still valid keeps the grant across a transfer.
   assign lock_hold_s = req_lock[sel_r] & req_valid[sel_r];
`else
   assign lock_hold_s = 1'b0;
`endif

   // Next-state, next-select and pointer update.
   always_comb begin
      state_nx = state_r;
      sel_nx   = sel_r;
      last_nx  = last_r;
      case (state_r)
         IDLE: begin
            if (pick_found_s) begin
               sel_nx   = pick_idx_s;
               state_nx = GRANT;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANT: begin
            if (xfer_s) begin
               if (lock_hold_s) begin
                  // Burst continues: select and pointer both frozen.
                  state_nx = GRANT;
               end else begin
                  last_nx = sel_r;
                  if (pick_found_s) begin
                     sel_nx   = pick_idx_s;
                     state_nx = GRANT;
                  end else begin
                     state_nx = IDLE;
                  end
               end
            end else if (!req_valid[sel_r]) begin
               // Requester withdrew before being accepted: drop the grant
               // without moving the pointer.
               state_nx = IDLE;
            end else begin
               state_nx = GRANT;
            end
         end
         default: begin
            state_nx = IDLE;
            sel_nx   = {SEL_W{1'b0}};
            last_nx  = {SEL_W{1'b1}};
         end
      endcase
   end

   // State, select and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         sel_r   <= {SEL_W{1'b0}};
         last_r  <= {SEL_W{1'b1}};
      end else begin
         state_r <= state_nx;
         sel_r   <= sel_nx;
         last_r  <= last_nx;
      end
   end

   assign out_valid = (state_r == GRANT);
   assign out_sel   = sel_r;

   // Output word follows the registered select.
   always_comb begin
      out_data = req_data[sel_r*DW +: DW];
   end

   // Acknowledge only the granted requester, and only when the word moves.
   always_comb begin
      if (xfer_s) begin
         req_ready = sel_onehot(sel_r);
      end else begin
         req_ready = {N_REQ{1'b0}};
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter8
// Directed, table-driven bench for rr_arbiter8. Each table row gives the
// inputs applied in one cycle and the outputs expected in that same cycle.
// -----------------------------------------------------------------------------
module tb_rr_arbiter8;

   logic         clk;
   logic         rst_n;
   logic [7:0]   req_valid;
   logic [255:0] req_data;
   logic [7:0]   req_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [2:0]   out_sel;
   logic         out_ready;
`ifdef ARB_LOCK_EN
   logic [7:0]   req_lock;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0] word [8];

   typedef struct {
      logic [7:0] valid;
      logic       ready;
      logic       ov;
      logic [2:0] sel;
      logic [7:0] rdy;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [NV];

   rr_arbiter8 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] v, input logic r, input logic ov,
                               input logic [2:0] s, input logic [7:0] rd);
      vec_t t;
      t.valid = v; t.ready = r; t.ov = ov; t.sel = s; t.rdy = rd;
      return t;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 8'h00;
      out_ready = 1'b0;
`ifdef ARB_LOCK_EN
      req_lock  = 8'h00;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         word[i] = 32'hA5A5_0000 | 32'(i * 32'h111);
      end
      word[3] = 32'hDEAD_BEEF;
      for (int i = 0; i < 8; i++) begin
         req_data[i*32 +: 32] = word[i];
      end

      // single request, no-bubble repeat, stall, withdrawal
      vecs[0]  = mk(8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
      vecs[1]  = mk(8'h08, 1'b1, 1'b0, 3'd0, 8'h00);
      vecs[2]  = mk(8'h08, 1'b1, 1'b1, 3'd3, 8'h08);
      vecs[3]  = mk(8'h08, 1'b0, 1'b1, 3'd3, 8'h00);
      vecs[4]  = mk(8'h00, 1'b0, 1'b1, 3'd3, 8'h00);
      vecs[5]  = mk(8'h00, 1'b0, 1'b0, 3'd3, 8'h00);
      // fairness with all valid, starting after last grant 3, wrapping 7 -> 0
      vecs[6]  = mk(8'hFF, 1'b1, 1'b0, 3'd3, 8'h00);
      vecs[7]  = mk(8'hFF, 1'b1, 1'b1, 3'd4, 8'h10);
      vecs[8]  = mk(8'hFF, 1'b1, 1'b1, 3'd5, 8'h20);
      vecs[9]  = mk(8'hFF, 1'b1, 1'b1, 3'd6, 8'h40);
      vecs[10] = mk(8'hFF, 1'b1, 1'b1, 3'd7, 8'h80);
      vecs[11] = mk(8'hFF, 1'b1, 1'b1, 3'd0, 8'h01);
      vecs[12] = mk(8'hFF, 1'b1, 1'b1, 3'd1, 8'h02);
      vecs[13] = mk(8'hFF, 1'b1, 1'b1, 3'd2, 8'h04);
      vecs[14] = mk(8'hFF, 1'b1, 1'b1, 3'd3, 8'h08);
      vecs[15] = mk(8'hFF, 1'b1, 1'b1, 3'd4, 8'h10);
      vecs[16] = mk(8'hFF, 1'b1, 1'b1, 3'd5, 8'h20);
      // stall and wrap: last grant 6, valid 0x41 -> 0 held, then 6
      vecs[17] = mk(8'h41, 1'b1, 1'b1, 3'd6, 8'h40);
      vecs[18] = mk(8'h41, 1'b0, 1'b1, 3'd0, 8'h00);
      vecs[19] = mk(8'h41, 1'b0, 1'b1, 3'd0, 8'h00);
      vecs[20] = mk(8'h41, 1'b0, 1'b1, 3'd0, 8'h00);
      vecs[21] = mk(8'h41, 1'b1, 1'b1, 3'd0, 8'h01);
      vecs[22] = mk(8'h00, 1'b0, 1'b1, 3'd6, 8'h00);
      vecs[23] = mk(8'h00, 1'b1, 1'b0, 3'd6, 8'h00);
      // withdrawal of requester 5; pointer must still be 0 afterwards
      vecs[24] = mk(8'h20, 1'b0, 1'b0, 3'd6, 8'h00);
      vecs[25] = mk(8'h20, 1'b0, 1'b1, 3'd5, 8'h00);
      vecs[26] = mk(8'h00, 1'b0, 1'b1, 3'd5, 8'h00);
      vecs[27] = mk(8'h03, 1'b1, 1'b0, 3'd5, 8'h00);
      vecs[28] = mk(8'h03, 1'b1, 1'b1, 3'd1, 8'h02);
      vecs[29] = mk(8'h01, 1'b1, 1'b1, 3'd0, 8'h01);
      vecs[30] = mk(8'h00, 1'b0, 1'b1, 3'd0, 8'h00);
      vecs[31] = mk(8'h00, 1'b0, 1'b0, 3'd0, 8'h00);

      do_reset();
      #2;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_sel",   32'(out_sel),   32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd0);

      // Inputs are applied 1 time unit after a rising edge and outputs are
      // sampled 2 units later, well away from either clock edge.
      for (int k = 0; k < NV; k++) begin
         next_cycle();
         req_valid = vecs[k].valid;
         out_ready = vecs[k].ready;
         #2;
         chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].ov));
         chk($sformatf("v%0d out_sel", k),   32'(out_sel),   32'(vecs[k].sel));
         chk($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(vecs[k].rdy));
         if (vecs[k].ov) begin
            chk($sformatf("v%0d out_data", k), out_data, word[vecs[k].sel]);
         end
      end

      // asynchronous reset while a grant is held
      next_cycle();
      req_valid = 8'h80;
      out_ready = 1'b0;
      next_cycle();
      #2;
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      chk("pre-reset out_sel",   32'(out_sel),   32'd7);
      out_ready = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 32'(out_valid), 32'd0);
      chk("async reset out_sel",   32'(out_sel),   32'd0);
      chk("async reset req_ready", 32'(req_ready), 32'd0);
      req_valid = 8'h00;
      out_ready = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      // pointer back at 7: with all valid, requester 0 wins first
      req_valid = 8'hFF;
      out_ready = 1'b1;
      next_cycle();
      #2;
      chk("post-reset first grant", 32'(out_sel), 32'd0);
      chk("post-reset req_ready",   32'(req_ready), 32'h01);
      next_cycle();
      #2;
      chk("post-reset second grant", 32'(out_sel), 32'd1);
      req_valid = 8'h00;
      out_ready = 1'b0;

`ifdef ARB_LOCK_EN
      // burst: lock on requester 0 for two transfers gives 0,0,1
      do_reset();
      req_valid = 8'h03;
      req_lock  = 8'h01;
      out_ready = 1'b1;
      next_cycle();
      #2;
      chk("lock grant a", 32'(out_sel), 32'd0);
      chk("lock ready a", 32'(req_ready), 32'h01);
      next_cycle();
      #2;
      chk("lock grant b", 32'(out_sel), 32'd0);
      chk("lock ready b", 32'(req_ready), 32'h01);
      req_lock = 8'h00;
      next_cycle();
      #2;
      chk("lock grant c", 32'(out_sel), 32'd1);
      chk("lock ready c", 32'(req_ready), 32'h02);
      req_valid = 8'h00;
      out_ready = 1'b0;
`endif

      next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one 32-bit result bus between eight producers.
- Producers are, for example, the ALU, shifter, multiplier/divider HI/LO, CP0 and load path.
- Each requester presents data with a valid/ready handshake. The block registers a 3-bit select and forwards the chosen word downstream with its own valid/ready handshake.
- Sits between the execution units and the shared write-back bus; it replaces a hard-wired select.

Parameters:
- DW, 32, data width of each requester and of the output.
- N_REQ, 8, number of requesters. Fixed at 8; the select width is 3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  8  per-requester valid; bit i belongs to requester i.
- req_data  in  8*DW  flattened data; requester i occupies bits [i*DW +: DW].
- req_ready  out  8  one-hot transfer acknowledge to requesters.
- out_valid  out  1  output word valid.
- out_data  out  DW  selected word.
- out_sel  out  3  index of the granted requester (registered).
- out_ready  in  1  downstream accept.
- req_lock  in  8  grant-hold request. Present only with ARB_LOCK_EN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_sel=0, state=IDLE, req_ready=0.
  - Pointer last_grant=7, so requester 0 has highest priority first.
- States:
  - IDLE: out_valid=0. If any req_valid, the pick is the first set bit searching upward from last_grant+1, modulo 8. The pick is registered into out_sel next edge; go to GRANT.
  - GRANT: out_valid=1; out_data = req_data slice selected by out_sel (combinational from out_sel).
- Latency: req_valid high in cycle t gives out_valid high in cycle t+1. There is no combinational path from req_valid to out_valid.
- Transfer: occurs when out_valid & out_ready. Then req_ready[out_sel]=1 in that same cycle; req_ready is out_ready gated by the grant. All other req_ready bits stay 0.
- On transfer:
  - last_grant <= out_sel.
  - The next pick is computed the same cycle from current req_valid, excluding the requester being served, with the pointer advanced.
  - If a request remains, stay in GRANT with the new out_sel. This gives back-to-back transfers at 1 word/cycle. Otherwise go to IDLE.
- Stall: out_valid=1 and out_ready=0 holds out_sel and state. out_data tracks the granted slice, and requesters keep data stable until ready.
- Withdrawal: if req_valid[out_sel] drops while in GRANT without a transfer:
  - Protocol violation; return to IDLE next edge with no transfer.
  - last_grant unchanged; out_valid=0 next cycle.
- Wrap-around: the search goes 7 -> 0 -> 1. With all 8 requesters valid, grants cycle 0,1,...,7,0.
- Single requester continuously valid: it is granted every cycle with no bubble (re-pick includes it if it is the only one).
- Reset mid-transfer: everything returns to reset values immediately; no word is considered transferred.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With ARB_LOCK_EN:
  - The req_lock port exists.
  - On a transfer where req_lock[out_sel]=1 and req_valid[out_sel] stays 1, the grant is retained. out_sel is unchanged and last_grant is not updated.
  - This supports multi-word bursts, e.g. HI then LO.
  - If the locked requester's valid drops, normal round-robin resumes from last_grant.
- Without it: the port is absent and there is pure round-robin after every transfer.

Decomposition:
- Package arb_pkg holds:
  - localparams N_REQ=8, SEL_W=3, DW=32.
  - state typedef/encoding IDLE=1'b0, GRANT=1'b1.
- One sub-module, rr_pick8: combinational rotating priority encoder.
  - Inputs: 8-bit request, 3-bit base.
  - Outputs: 3-bit index and a found flag.
  - Used for both the IDLE pick and the re-pick on transfer.

Test Plan:
- Reset: rst_n=0 then 1, no requests -> out_valid=0, out_sel=0, req_ready=0x00. Asserting rst_n=0 mid-GRANT forces out_valid=0 asynchronously.
- Single request: req_valid=0x08, req_data[3]=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_sel=3, out_data=0xDEADBEEF, req_ready=0x08.
- Fairness: req_valid=0xFF held, out_ready=1 -> out_sel sequence 0,1,2,...,7,0 on consecutive cycles, one transfer per cycle.
- Stall and wrap: last grant 6, req_valid=0x41, out_ready=0 for 3 cycles -> out_sel=0, held stable, req_ready=0x00. Then out_ready=1 -> req_ready=0x01, next out_sel=6.
- Withdrawal: granted requester 5 drops valid with out_ready=0 -> IDLE next cycle, out_valid=0, no req_ready pulse, next pick still starts after previous last_grant.
- Lock (ARB_LOCK_EN): req_valid=0x03, req_lock=0x01 for 2 transfers -> out_sel 0,0,1 rather than 0,1,0.
